dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Two-port arbiter in front of dram_controller's user-side command interface (i_rd_en/i_wr_en/i_addr/i_data/i_mask, o_ready/o_wdf_ready, o_data/o_data_valid), running on the MIG ui clock.
- Shares the single DRAM command path between two requesters (e.g. pulse-pattern loader and playback reader) with round-robin fairness.
- Routes in-order read returns back to the issuing port via a tag FIFO.

Parameters:
- APP_ADDR_WIDTH, 28, command address width.
- APP_DATA_WIDTH, 128, data width.
- APP_MASK_WIDTH, 16, write byte-mask width.
- RD_TAG_DEPTH, 16, maximum outstanding reads; power of two, minimum 2.

Ports:
- clk  in  1  MIG ui clock; all logic on its rising edge.
- i_rst  in  1  asynchronous active-high reset.
- pN_req  in  1  port N (N=0,1) command request; held with fields stable until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  APP_ADDR_WIDTH  command address.
- pN_data  in  APP_DATA_WIDTH  write data.
- pN_mask  in  APP_MASK_WIDTH  write mask (1 = byte masked).
- pN_ack  out  1  single-cycle pulse: command accepted downstream.
- pN_rd_data  out  APP_DATA_WIDTH  read return data.
- pN_rd_valid  out  1  read return strobe.
- m_rd_en, m_wr_en  out  1  to dram_controller i_rd_en/i_wr_en.
- m_addr  out  APP_ADDR_WIDTH  to i_addr.
- m_data  out  APP_DATA_WIDTH  to i_data.
- m_mask  out  APP_MASK_WIDTH  to i_mask.
- m_ready, m_wdf_ready  in  1  from o_ready/o_wdf_ready.
- m_rd_data  in  APP_DATA_WIDTH  from o_data.
- m_rd_valid  in  1  from o_data_valid.
- m_calib_done  in  1  from o_init_calib_complete.
- o_rd_pending  out  $clog2(RD_TAG_DEPTH)+1  outstanding read count.
- o_err  out  1  sticky: read return arrived with empty tag FIFO.

Behaviour:
- Reset (async): state IDLE, rr pointer = port 0 preferred, tag FIFO empty. All outputs 0: m_*_en, m_addr/data/mask, pN_ack, pN_rd_valid, pN_rd_data, o_rd_pending, o_err.
- Downstream acceptance:
  - Read accepted when m_rd_en && m_ready.
  - Write accepted when m_wr_en && m_ready && m_wdf_ready (data and command in the same cycle; controller ties wdf_end to wdf_wren).
- Eligibility: pN_req=1, m_calib_done=1, and, for reads (pN_we=0), tag FIFO not full.
- FSM IDLE:
  - No eligible port: stay.
  - One eligible port: grant it.
  - Both eligible: grant the port opposite the last granted port (rr pointer).
  - On grant: register owner, command fields and enable into m_* outputs; go ISSUE. Request-to-m_*_en latency is 1 cycle.
- FSM ISSUE:
  - Hold m_* stable until accepted. No preemption; m_calib_done deassertion does not retract an issued command.
  - On the accept cycle: pN_ack=1 for the owner (combinational on accept), m_*_en cleared at the next edge, rr pointer set to owner, read pushes the owner id into the tag FIFO, return to IDLE.
  - Peak throughput is one command per 2 cycles.
- Read return:
  - On m_rd_valid, pop the tag FIFO head.
  - Next cycle: pN_rd_data = m_rd_data and pN_rd_valid=1 for the tagged port only. The other port's valid stays 0 and its data holds.
  - Returns are in issue order.
- Simultaneous push and pop in one cycle: both happen, count unchanged; legal when full (pop frees the slot, but grant eligibility uses the start-of-cycle full flag).
- o_rd_pending = FIFO occupancy (push +1, pop -1, both 0); range 0..RD_TAG_DEPTH.
- m_rd_valid with FIFO empty: data discarded, no pN_rd_valid, o_err set until reset.
- Reset mid-operation: in-flight command and outstanding tags are lost; the requester re-issues after reset.

Test Plan:
- Calib gating: m_calib_done=0, p0_req write -> no m_wr_en for 20 cycles. Raise calib -> m_wr_en=1 one cycle later; p0_ack on first cycle with m_ready=m_wdf_ready=1.
- Write backpressure: m_ready=1, m_wdf_ready=0 for 5 cycles -> m_wr_en/m_addr/m_data held stable, no ack. Then m_wdf_ready=1 -> single p0_ack pulse.
- Round-robin: both ports continuously request 8 commands each -> grants strictly alternate 0,1,0,1..., 16 acks total, no port starved.
- Read routing: p0 reads A0, p1 reads A1, p0 reads A2; return D0, D1, D2 -> p0 gets D0 then D2, p1 gets D1, each one cycle after m_rd_valid; o_rd_pending goes 3->0.
- Tag full: RD_TAG_DEPTH=4, issue 4 reads with no returns -> 5th read not granted, but a p1 write is still granted. One return -> 5th read issues; o_rd_pending never exceeds 4.
- Error and reset: m_rd_valid with empty FIFO -> o_err=1, no pN_rd_valid. Assert i_rst mid-ISSUE -> all outputs 0 immediately (asynchronously), o_err cleared.

Source files
------------

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port round-robin arbiter in front of the DRAM controller user interface
// Ports:
//   clk, i_rst                       MIG ui clock, asynchronous active-high reset
//   p0_*/p1_* req/we/addr/data/mask  requester commands, held until pN_ack
//   p0_*/p1_* ack, rd_data, rd_valid accept pulse and routed read returns
//   m_rd_en/m_wr_en/m_addr/m_data/m_mask, m_ready/m_wdf_ready  controller command side
//   m_rd_data/m_rd_valid, m_calib_done  controller read return and calibration status
//   o_rd_pending, o_err              outstanding read count, sticky orphan-return flag

module dram_arbiter_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   push_tag_i,
  input  logic                   pop_i,
  output logic                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] tags_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = tags_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        tags_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module dram_arbiter #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int RD_TAG_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          p0_req,
  input  logic                          p0_we,
  input  logic [APP_ADDR_WIDTH-1:0]     p0_addr,
  input  logic [APP_DATA_WIDTH-1:0]     p0_data,
  input  logic [APP_MASK_WIDTH-1:0]     p0_mask,
  output logic                          p0_ack,
  output logic [APP_DATA_WIDTH-1:0]     p0_rd_data,
  output logic                          p0_rd_valid,
  input  logic                          p1_req,
  input  logic                          p1_we,
  input  logic [APP_ADDR_WIDTH-1:0]     p1_addr,
  input  logic [APP_DATA_WIDTH-1:0]     p1_data,
  input  logic [APP_MASK_WIDTH-1:0]     p1_mask,
  output logic                          p1_ack,
  output logic [APP_DATA_WIDTH-1:0]     p1_rd_data,
  output logic                          p1_rd_valid,
  output logic                          m_rd_en,
  output logic                          m_wr_en,
  output logic [APP_ADDR_WIDTH-1:0]     m_addr,
  output logic [APP_DATA_WIDTH-1:0]     m_data,
  output logic [APP_MASK_WIDTH-1:0]     m_mask,
  input  logic                          m_ready,
  input  logic                          m_wdf_ready,
  input  logic [APP_DATA_WIDTH-1:0]     m_rd_data,
  input  logic                          m_rd_valid,
  input  logic                          m_calib_done,
  output logic [$clog2(RD_TAG_DEPTH):0] o_rd_pending,
  output logic                          o_err
);
  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic                      rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APP_DATA_WIDTH-1:0] data_q, data_d;
  logic [APP_MASK_WIDTH-1:0] mask_q, mask_d;
  logic [APP_DATA_WIDTH-1:0] p0_rd_data_q, p1_rd_data_q;
  logic [1:0]                rd_valid_q;
  logic                      err_q;
  logic                      elig0, elig1, sel, accept;
  logic                      tag_full, tag_empty, tag_head;

  // Reads need a free tag slot at grant time; writes never consume one.
  assign elig0  = p0_req && m_calib_done && (p0_we || !tag_full);
  assign elig1  = p1_req && m_calib_done && (p1_we || !tag_full);
  assign accept = (state_q == ST_ISSUE) &&
                  ((rd_en_q && m_ready) || (wr_en_q && m_ready && m_wdf_ready));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    sel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0 || elig1) begin
          // On contention, favour the port that did not win last time.
          sel     = (elig0 && elig1) ? !last_q : elig1;
          owner_d = sel;
          rd_en_d = sel ? !p1_we : !p0_we;
          wr_en_d = sel ? p1_we : p0_we;
          addr_d  = sel ? p1_addr : p0_addr;
          data_d  = sel ? p1_data : p0_data;
          mask_d  = sel ? p1_mask : p0_mask;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // pretend port 1 won last so port 0 is preferred first
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  dram_arbiter_tag_fifo #(.DEPTH(RD_TAG_DEPTH)) u_tag_fifo (
    .clk        (clk),
    .rst        (i_rst),
    .push_i     (accept && rd_en_q),
    .push_tag_i (owner_q),
    .pop_i      (m_rd_valid),
    .head_o     (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .count_o    (o_rd_pending)
  );

  // Returns are in issue order, so the FIFO head names the destination port.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rd_valid_q   <= 2'b00;
      p0_rd_data_q <= '0;
      p1_rd_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      rd_valid_q <= 2'b00;
      if (m_rd_valid) begin
        if (tag_empty) begin
          err_q <= 1'b1;
        end else if (tag_head) begin
          rd_valid_q[1] <= 1'b1;
          p1_rd_data_q  <= m_rd_data;
        end else begin
          rd_valid_q[0] <= 1'b1;
          p0_rd_data_q  <= m_rd_data;
        end
      end
    end
  end

  assign p0_ack      = accept && !owner_q;
  assign p1_ack      = accept && owner_q;
  assign p0_rd_valid = rd_valid_q[0];
  assign p1_rd_valid = rd_valid_q[1];
  assign p0_rd_data  = p0_rd_data_q;
  assign p1_rd_data  = p1_rd_data_q;
  assign m_rd_en     = rd_en_q;
  assign m_wr_en     = wr_en_q;
  assign m_addr      = addr_q;
  assign m_data      = data_q;
  assign m_mask      = mask_q;
  assign o_err       = err_q;
endmodule
